// File: rtl/decoder_issue_sequencer_if.sv
// Host request port and decoder drive bundle for decoder_issue_sequencer.
// The slave side is the sequencer; the master side is the host/decoder environment.
interface decoder_issue_sequencer_if;
  logic       req_valid;
  logic [4:0] req_instr;
  logic       req_cc;
  logic       req_ready;
  logic [2:0] dec_id;
  logic [4:0] dec_instr;
  logic       dec_cc;
  logic       dec_instr_en;

  modport master (
    output req_valid, req_instr, req_cc,
    input  req_ready, dec_id, dec_instr, dec_cc, dec_instr_en
  );

  modport slave (
    input  req_valid, req_instr, req_cc,
    output req_ready, dec_id, dec_instr, dec_cc, dec_instr_en
  );
endinterface

// File: rtl/decoder_issue_sequencer.sv
// Queues host micro-ops and issues them one per clock to the instruction decoder.
// Optional SEQ_PERF_EN adds saturating issue/stall performance counters.
//
// state | meaning
// IDLE  | decoder deselected (id=0, en=1); pops head when queue non-empty and !hold
// ISSUE | one-cycle execute pulse of the popped op (id=ID_VALUE, en=0)
// WAIT  | adder wait after Fetch R+D: decoder disable op held for ADD_WAIT cycles
module decoder_issue_sequencer #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned ADD_WAIT    = 1,
  parameter logic [2:0]  ID_VALUE    = 3'b010
) (
  input  logic                               clk,
  input  logic                               rst_n,
  decoder_issue_sequencer_if.slave           bus,
  input  logic                               hold,
  input  logic                               stack_clr,
  input  logic                               err_clr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
  output logic                               err_ovf,
  output logic                               err_ill,
  output logic                               busy
`ifdef SEQ_PERF_EN
  ,
  output logic [15:0]                        perf_issued,
  output logic [15:0]                        perf_stall
`endif
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);

  localparam logic [4:0] OP_DISABLE  = 5'b01000;
  localparam logic [4:0] OP_FETCH_RD = 5'b01001;
  localparam logic [4:0] OP_PUSH_PC  = 5'b01011;
  localparam logic [4:0] OP_LAST     = 5'b01011;
  localparam logic [3:0] WAIT_LOAD   = 4'((ADD_WAIT == 0) ? 0 : (ADD_WAIT - 1));

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic [5:0]      mem_q [FIFO_DEPTH];
  logic [5:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            ovf_q, ovf_d, ill_q, ill_d;
  logic [2:0]      dec_id_q, dec_id_d;
  logic [4:0]      dec_instr_q, dec_instr_d;
  logic            dec_cc_q, dec_cc_d;
  logic            dec_en_q, dec_en_d;

  logic            can_push, push, pop, pop_window, push_issue;
  logic            set_ovf, set_ill, head_ill, stack_full;
  logic [4:0]      head_instr;
  logic            head_cc;

  always_comb begin
    can_push   = (count_q != CW'(FIFO_DEPTH));
    push       = bus.req_valid && can_push;
    head_instr = mem_q[rd_ptr_q][5:1];
    head_cc    = mem_q[rd_ptr_q][0];
    head_ill   = (head_instr < OP_DISABLE) || (head_instr > OP_LAST);
    stack_full = (depth_q == DW'(STACK_DEPTH));

    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    dec_id_d    = 3'b000;
    dec_instr_d = 5'b00000;
    dec_cc_d    = 1'b0;
    dec_en_d    = 1'b1;
    pop         = 1'b0;
    pop_window  = 1'b0;
    push_issue  = 1'b0;
    set_ovf     = 1'b0;
    set_ill     = 1'b0;

    case (state_q)
      S_IDLE: pop_window = 1'b1;
      S_ISSUE: begin
        if ((dec_instr_q == OP_FETCH_RD) && (ADD_WAIT != 0)) begin
          state_d     = S_WAIT;
          wait_cnt_d  = WAIT_LOAD;
          dec_id_d    = ID_VALUE;
          dec_instr_d = OP_DISABLE;
          dec_cc_d    = 1'b1;
        end else begin
          pop_window = 1'b1;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q != 4'd0) begin
          wait_cnt_d  = wait_cnt_q - 4'd1;
          dec_id_d    = ID_VALUE;
          dec_instr_d = OP_DISABLE;
          dec_cc_d    = 1'b1;
        end else begin
          pop_window = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Dropped entries are consumed silently; the FSM re-decides next cycle from IDLE.
    if (pop_window) begin
      state_d = S_IDLE;
      if ((count_q != '0) && !hold) begin
        pop = 1'b1;
        if (head_ill) begin
          set_ill = 1'b1;
        end else if ((head_instr == OP_PUSH_PC) && stack_full) begin
          set_ovf = 1'b1;
        end else begin
          state_d     = S_ISSUE;
          dec_id_d    = ID_VALUE;
          dec_instr_d = head_instr;
          dec_cc_d    = head_cc;
          dec_en_d    = 1'b0;
          push_issue  = (head_instr == OP_PUSH_PC);
        end
      end
    end

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {bus.req_instr, bus.req_cc};
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    depth_d = stack_clr ? DW'(push_issue) : (depth_q + DW'(push_issue));
    ovf_d   = (ovf_q && !err_clr) || set_ovf;
    ill_d   = (ill_q && !err_clr) || set_ill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= 4'd0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 6'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      depth_q     <= '0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
      dec_id_q    <= 3'b000;
      dec_instr_q <= 5'b00000;
      dec_cc_q    <= 1'b0;
      dec_en_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      depth_q     <= depth_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
      dec_id_q    <= dec_id_d;
      dec_instr_q <= dec_instr_d;
      dec_cc_q    <= dec_cc_d;
      dec_en_q    <= dec_en_d;
    end
  end

  assign bus.req_ready    = can_push;
  assign bus.dec_id       = dec_id_q;
  assign bus.dec_instr    = dec_instr_q;
  assign bus.dec_cc       = dec_cc_q;
  assign bus.dec_instr_en = dec_en_q;
  assign stack_depth      = depth_q;
  assign err_ovf          = ovf_q;
  assign err_ill          = ill_q;
  assign busy             = (count_q != '0) || (state_q != S_IDLE);

`ifdef SEQ_PERF_EN
  logic [15:0] perf_issued_q, perf_issued_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_issued_d = perf_issued_q;
    perf_stall_d  = perf_stall_q;
    if (err_clr) begin
      perf_issued_d = 16'd0;
      perf_stall_d  = 16'd0;
    end else begin
      if ((state_q == S_ISSUE) && (perf_issued_q != 16'hFFFF)) perf_issued_d = perf_issued_q + 16'd1;
      if ((count_q != '0) && !pop && (perf_stall_q != 16'hFFFF)) perf_stall_d = perf_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued_q <= 16'd0;
      perf_stall_q  <= 16'd0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif
endmodule

// File: tb/tb_decoder_issue_sequencer.sv
// Directed bench for decoder_issue_sequencer: queue-based reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_decoder_issue_sequencer;
  localparam int         FD  = 4;
  localparam int         SD  = 2;
  localparam int         AW  = 2;
  localparam logic [2:0] IDV = 3'b010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hold = 1'b0, stack_clr = 1'b0, err_clr = 1'b0;
  logic [1:0] stack_depth;
  logic       err_ovf, err_ill, busy;
`ifdef SEQ_PERF_EN
  logic [15:0] perf_issued, perf_stall;
`endif

  decoder_issue_sequencer_if bus_if();

  decoder_issue_sequencer #(
    .FIFO_DEPTH(FD), .STACK_DEPTH(SD), .ADD_WAIT(AW), .ID_VALUE(IDV)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus_if),
    .hold(hold),
    .stack_clr(stack_clr),
    .err_clr(err_clr),
    .stack_depth(stack_depth),
    .err_ovf(err_ovf),
    .err_ill(err_ill),
    .busy(busy)
`ifdef SEQ_PERF_EN
    ,
    .perf_issued(perf_issued),
    .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of {instr,cc}, remaining wait cycles, and expected outputs.
  logic [5:0] mq[$];
  int         m_wait = 0;
  int         m_depth = 0;
  bit         m_ovf = 0, m_ill = 0;
  logic [2:0] e_id = 3'b000;
  logic [4:0] e_instr = 5'b0;
  logic       e_cc = 1'b0, e_en = 1'b1;
  int         pre_size;
  bit         m_push, set_i, set_o;
  logic [5:0] h;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_wait = 0; m_depth = 0; m_ovf = 0; m_ill = 0;
      e_id = 3'b000; e_instr = 5'b0; e_cc = 1'b0; e_en = 1'b1;
    end else begin
      pre_size = mq.size();
      m_push = 0; set_i = 0; set_o = 0;
      if (m_wait > 0) begin
        e_id = IDV; e_instr = 5'b01000; e_cc = 1'b1; e_en = 1'b1;
        m_wait--;
      end else begin
        e_id = 3'b000; e_instr = 5'b0; e_cc = 1'b0; e_en = 1'b1;
        if (pre_size > 0 && !hold) begin
          h = mq.pop_front();
          if (h[5:1] < 5'd8 || h[5:1] > 5'd11) set_i = 1;
          else if (h[5:1] == 5'd11 && m_depth == SD) set_o = 1;
          else begin
            e_id = IDV; e_instr = h[5:1]; e_cc = h[0]; e_en = 1'b0;
            if (h[5:1] == 5'd9) m_wait = AW;
            if (h[5:1] == 5'd11) m_push = 1;
          end
        end
      end
      if (bus_if.req_valid && pre_size < FD) mq.push_back({bus_if.req_instr, bus_if.req_cc});
      m_depth = stack_clr ? int'(m_push) : m_depth + int'(m_push);
      m_ill = (m_ill && !err_clr) || set_i;
      m_ovf = (m_ovf && !err_clr) || set_o;
    end
  end

  always @(negedge clk) begin
    chk("dec_id", 32'(bus_if.dec_id), 32'(e_id));
    chk("dec_instr", 32'(bus_if.dec_instr), 32'(e_instr));
    chk("dec_cc", 32'(bus_if.dec_cc), 32'(e_cc));
    chk("dec_instr_en", 32'(bus_if.dec_instr_en), 32'(e_en));
    chk("stack_depth", 32'(stack_depth), 32'(m_depth));
    chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
    chk("err_ill", 32'(err_ill), 32'(m_ill));
    chk("req_ready", 32'(bus_if.req_ready), 32'(mq.size() < FD));
    chk("busy", 32'(busy), 32'((mq.size() != 0) || (e_id != 3'b000)));
  end

  task automatic send(input logic [4:0] i, input logic c);
    bus_if.req_valid = 1'b1; bus_if.req_instr = i; bus_if.req_cc = c;
    @(negedge clk);
  endtask

  task automatic quiet(input int n);
    bus_if.req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_dec(input string nm, input logic [2:0] id, input logic [4:0] ins,
                         input logic cc, input logic en);
    chk({nm, ".id"}, 32'(bus_if.dec_id), 32'(id));
    chk({nm, ".instr"}, 32'(bus_if.dec_instr), 32'(ins));
    chk({nm, ".cc"}, 32'(bus_if.dec_cc), 32'(cc));
    chk({nm, ".en"}, 32'(bus_if.dec_instr_en), 32'(en));
  endtask

  initial begin
    bus_if.req_valid = 1'b0; bus_if.req_instr = 5'b0; bus_if.req_cc = 1'b0;
    repeat (2) @(negedge clk);
    chk_dec("rst", 3'b000, 5'b00000, 1'b0, 1'b1);
    chk("rst.ready", 32'(bus_if.req_ready), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.depth", 32'(stack_depth), 32'd0);
    rst_n = 1'b1;
    quiet(1);

    // 1: single op, one-cycle pulse at k+1
    send(5'b01000, 1'b0);
    quiet(1);
    chk_dec("s1.issue", 3'b010, 5'b01000, 1'b0, 1'b0);
    quiet(1);
    chk_dec("s1.idle", 3'b000, 5'b00000, 1'b0, 1'b1);
    chk("s1.busy", 32'(busy), 32'd0);

    // 2: back-to-back issue, push increments depth on its issue edge
    send(5'b01010, 1'b0);
    send(5'b01011, 1'b0);
    chk_dec("s2.op1", 3'b010, 5'b01010, 1'b0, 1'b0);
    chk("s2.depth0", 32'(stack_depth), 32'd0);
    send(5'b01000, 1'b1);
    chk_dec("s2.op2", 3'b010, 5'b01011, 1'b0, 1'b0);
    chk("s2.depth1", 32'(stack_depth), 32'd1);
    quiet(1);
    chk_dec("s2.op3", 3'b010, 5'b01000, 1'b1, 1'b0);
    quiet(1);

    // 3: Fetch R+D followed by two wait cycles; hold is ignored during the wait
    send(5'b01001, 1'b0);
    send(5'b01000, 1'b0);
    chk_dec("s3.fetch", 3'b010, 5'b01001, 1'b0, 1'b0);
    quiet(1);
    chk_dec("s3.wait1", 3'b010, 5'b01000, 1'b1, 1'b1);
    hold = 1'b1;
    quiet(1);
    chk_dec("s3.wait2", 3'b010, 5'b01000, 1'b1, 1'b1);
    quiet(1);
    chk_dec("s3.held", 3'b000, 5'b00000, 1'b0, 1'b1);
    chk("s3.busy_held", 32'(busy), 32'd1);
    hold = 1'b0;
    quiet(1);
    chk_dec("s3.op2", 3'b010, 5'b01000, 1'b0, 1'b0);
    quiet(1);

    // 4: stack overflow drop, error clear, stack clear, clear coincident with push
    stack_clr = 1'b1; quiet(1); stack_clr = 1'b0;
    chk("s4.clr", 32'(stack_depth), 32'd0);
    send(5'b01011, 1'b0);
    send(5'b01011, 1'b0);
    send(5'b01011, 1'b0);
    quiet(1);
    chk("s4.depth_full", 32'(stack_depth), 32'd2);
    chk("s4.ovf", 32'(err_ovf), 32'd1);
    chk_dec("s4.no_pulse", 3'b000, 5'b00000, 1'b0, 1'b1);
    err_clr = 1'b1; quiet(1); err_clr = 1'b0;
    chk("s4.ovf_clr", 32'(err_ovf), 32'd0);
    stack_clr = 1'b1; quiet(1); stack_clr = 1'b0;
    chk("s4.depth_clr", 32'(stack_depth), 32'd0);
    send(5'b01011, 1'b0);
    stack_clr = 1'b1; quiet(1); stack_clr = 1'b0;
    chk("s4.clr_push", 32'(stack_depth), 32'd1);
    quiet(1);

    // 5: illegal drop with coincident err_clr, fill under hold, no bypass when full
    send(5'b11111, 1'b0);
    err_clr = 1'b1; quiet(1); err_clr = 1'b0;
    chk("s5.ill", 32'(err_ill), 32'd1);
    chk_dec("s5.no_pulse", 3'b000, 5'b00000, 1'b0, 1'b1);
    quiet(1);
    chk("s5.ill_sticky", 32'(err_ill), 32'd1);
    err_clr = 1'b1; quiet(1); err_clr = 1'b0;
    chk("s5.ill_clr", 32'(err_ill), 32'd0);
    hold = 1'b1;
    send(5'b01000, 1'b0);
    send(5'b01010, 1'b1);
    send(5'b01001, 1'b1);
    send(5'b01010, 1'b0);
    chk("s5.full_ready", 32'(bus_if.req_ready), 32'd0);
    chk("s5.full_busy", 32'(busy), 32'd1);
    hold = 1'b0;
    send(5'b01011, 1'b1);
    chk_dec("s5.d1", 3'b010, 5'b01000, 1'b0, 1'b0);
    quiet(1);
    chk_dec("s5.d2", 3'b010, 5'b01010, 1'b1, 1'b0);
    quiet(1);
    chk_dec("s5.d3", 3'b010, 5'b01001, 1'b1, 1'b0);
    quiet(3);
    chk_dec("s5.d4", 3'b010, 5'b01010, 1'b0, 1'b0);
    quiet(1);
    chk("s5.drained", 32'(busy), 32'd0);
    chk("s5.depth_kept", 32'(stack_depth), 32'd1);

    // 6: async reset in the middle of a wait
    send(5'b01001, 1'b0);
    quiet(2);
    chk_dec("s6.in_wait", 3'b010, 5'b01000, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_dec("s6.rst", 3'b000, 5'b00000, 1'b0, 1'b1);
    chk("s6.busy", 32'(busy), 32'd0);
    chk("s6.ready", 32'(bus_if.req_ready), 32'd1);
    chk("s6.depth", 32'(stack_depth), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
